// File: rtl/sha256_serial_add_ctrl.sv
// Bit-serial multi-operand adder controller: one full-adder slice, LSB first,
// accumulates up to NUM_OPS operands modulo 2^WIDTH behind valid/ready handshakes.
module sha256_serial_add_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_OPS = 5,
    parameter int unsigned CNT_W   = $clog2(NUM_OPS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CNT_W-1:0]         op_count,
    input  logic [NUM_OPS*WIDTH-1:0] operands,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         sum,
    output logic                     carry_seen,
    output logic                     busy
);

    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned BUS_W = NUM_OPS * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BUS_W-1:0]   bank_q, bank_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opreg_q, opreg_d;
    logic               carry_q, carry_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_seen_q, carry_seen_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic               fa_sum_c;
    logic               fa_cout_c;
    logic [CNT_W-1:0]   k_clamp_c;

    // Select operand idx from a packed operand bus without a variable part-select.
    function automatic logic [WIDTH-1:0] op_sel(input logic [BUS_W-1:0] bus,
                                                input int unsigned       idx);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_OPS; i++) begin
            if (i == idx) r = bus[i*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    // Single full-adder slice shared across all bits and passes.
    always_comb begin
        fa_sum_c  = acc_q[0] ^ opreg_q[0] ^ carry_q;
        fa_cout_c = (acc_q[0] & opreg_q[0]) | (carry_q & (acc_q[0] ^ opreg_q[0]));
    end

    always_comb begin
        k_clamp_c = op_count;
        if (op_count == '0) begin
            k_clamp_c = CNT_W'(1);
        end else if (op_count > CNT_W'(NUM_OPS)) begin
            k_clamp_c = CNT_W'(NUM_OPS);
        end
    end

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        acc_d        = acc_q;
        opreg_d      = opreg_q;
        carry_d      = carry_q;
        bit_cnt_d    = bit_cnt_q;
        pass_d       = pass_q;
        k_d          = k_q;
        sum_d        = sum_q;
        carry_seen_d = carry_seen_q;
        out_valid_d  = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bank_d       = operands;
                    acc_d        = op_sel(operands, 32'd0);
                    opreg_d      = op_sel(operands, 32'd1);
                    k_d          = k_clamp_c;
                    carry_d      = 1'b0;
                    bit_cnt_d    = '0;
                    carry_seen_d = 1'b0;
                    pass_d       = CNT_W'(1);
                    state_d      = (k_clamp_c > CNT_W'(1)) ? ADD : DONE;
                end
            end
            ADD: begin
                acc_d            = acc_q >> 1;
                acc_d[WIDTH-1]   = fa_sum_c;
                opreg_d          = opreg_q >> 1;
                carry_d          = fa_cout_c;
                bit_cnt_d        = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                    // End of a pass: carry out of the MSB is dropped (mod 2^WIDTH).
                    carry_d   = 1'b0;
                    bit_cnt_d = '0;
                    if (fa_cout_c) carry_seen_d = 1'b1;
                    if (pass_q == k_q - CNT_W'(1)) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        sum_d       = acc_d;
                    end else begin
                        pass_d  = pass_q + CNT_W'(1);
                        opreg_d = op_sel(bank_q, 32'(pass_q) + 32'd1);
                    end
                end
            end
            DONE: begin
                // Single-operand requests arrive here with out_valid still low.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    sum_d       = acc_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bank_q       <= '0;
            acc_q        <= '0;
            opreg_q      <= '0;
            carry_q      <= 1'b0;
            bit_cnt_q    <= '0;
            pass_q       <= '0;
            k_q          <= '0;
            sum_q        <= '0;
            carry_seen_q <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            acc_q        <= acc_d;
            opreg_q      <= opreg_d;
            carry_q      <= carry_d;
            bit_cnt_q    <= bit_cnt_d;
            pass_q       <= pass_d;
            k_q          <= k_d;
            sum_q        <= sum_d;
            carry_seen_q <= carry_seen_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign sum        = sum_q;
    assign carry_seen = carry_seen_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sha256_serial_add_ctrl.sv
// Directed bench for sha256_serial_add_ctrl: latency, sums, carry flag,
// operand clamping, backpressure and mid-operation reset.
module tb_sha256_serial_add_ctrl;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned NUM_OPS = 5;
    localparam int unsigned CNT_W   = $clog2(NUM_OPS + 1);
    localparam int unsigned BUDGET  = 1000;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [CNT_W-1:0]         op_count;
    logic [NUM_OPS*WIDTH-1:0] operands;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         sum;
    logic                     carry_seen;
    logic                     busy;

    int checks;
    int errors;

    sha256_serial_add_ctrl #(
        .WIDTH   (WIDTH),
        .NUM_OPS (NUM_OPS),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_count   (op_count),
        .operands   (operands),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .carry_seen (carry_seen),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, time out_valid, check result, optionally stall the consumer.
    task automatic run_req(input string tag, input logic [CNT_W-1:0] cnt,
                           input logic [31:0] o0, input logic [31:0] o1,
                           input logic [31:0] o2, input logic [31:0] o3,
                           input logic [31:0] o4, input logic [31:0] exp_sum,
                           input logic exp_carry, input int exp_lat,
                           input bit keep_valid, input int stall);
        int lat;
        logic [31:0] prev_sum;
        prev_sum = sum;
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_count = cnt;
        operands = {o4, o3, o2, o1, o0};
        tick();
        if (!keep_valid) in_valid = 1'b0;
        op_count = CNT_W'(1);
        operands = {$urandom, $urandom, $urandom, $urandom, $urandom};
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (lat < BUDGET) begin
            tick();
            lat++;
            if (out_valid) break;
            if (lat == 5) check({tag, " sum held during add"}, sum, prev_sum);
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " sum"}, sum, exp_sum);
        check({tag, " carry_seen"}, 32'(carry_seen), 32'(exp_carry));
        if (stall > 0) begin
            out_ready = 1'b0;
            repeat (stall) tick();
            check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " stall sum"}, sum, exp_sum);
            check({tag, " stall carry_seen"}, 32'(carry_seen), 32'(exp_carry));
            check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
        check({tag, " sum retained"}, sum, exp_sum);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_count  = '0;
        operands  = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", sum, 32'd0);
        check("reset carry_seen", 32'(carry_seen), 32'd0);
        check("reset busy", 32'(busy), 32'd0);

        // Stray out_ready in IDLE must do nothing.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle out_ready out_valid", 32'(out_valid), 32'd0);

        run_req("k2 small", 3'd2, 32'h1, 32'h2, 0, 0, 0, 32'h3, 1'b0, 32, 1'b0, 0);
        run_req("k2 sha", 3'd2, 32'h6A09E667, 32'hBB67AE85, 0, 0, 0,
                32'h257194EC, 1'b1, 32, 1'b1, 10);
        run_req("k5 msb", 3'd5, 32'h80000000, 32'h80000000, 32'h80000000,
                32'h80000000, 32'h80000000, 32'h80000000, 1'b1, 128, 1'b0, 0);
        run_req("k5 wrap", 3'd5, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h0, 1'b1, 128, 1'b0, 0);
        run_req("k1", 3'd1, 32'hDEADBEEF, 32'h11111111, 0, 0, 0,
                32'hDEADBEEF, 1'b0, 1, 1'b0, 0);
        run_req("k0", 3'd0, 32'hDEADBEEF, 32'h22222222, 0, 0, 0,
                32'hDEADBEEF, 1'b0, 1, 1'b0, 0);
        run_req("k7 clamp", 3'd7, 32'h1, 32'h10, 32'h100, 32'h1000, 32'h10000,
                32'h00011111, 1'b0, 128, 1'b1, 0);

        // Reset 40 cycles into a five-operand request.
        in_valid = 1'b1;
        op_count = 3'd5;
        operands = {5{32'h12345678}};
        tick();
        in_valid = 1'b0;
        repeat (39) tick();
        check("midreset busy before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset sum", sum, 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset in_ready", 32'(in_ready), 32'd1);
        run_req("post reset", 3'd2, 32'h3, 32'h4, 0, 0, 0, 32'h7, 1'b0, 32, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
